window_buffer_kxk: RTL and testbench

Parametrised KxK sliding-window generator for the Canny pipeline, the generalised successor of the fixed 3x3 NMS window stage. It accepts a raster pixel stream with gaps, holds KSZ-1 previous lines in internal line RAMs, and emits one full KSZ×KSZ window plus its centre pixel for every valid (non-border) output position. It adds frame-start resynchronisation, per-frame latched geometry, position flags and error reporting. It feeds the Gaussian, Sobel and NMS kernels.

---
 rtl/window_buffer_kxk.sv | 195 +++++++++++++++++++
 tb/tb_window_buffer_kxk.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_buffer_kxk.sv
// rtl/window_buffer_kxk.sv - KxK sliding-window generator with line RAMs, frame resync and error flags
module window_buffer_kxk #(
  parameter int KSZ     = 3,
  parameter int DATAWID = 8,
  parameter int MAX_IW  = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           din_valid,
  input  logic [DATAWID-1:0]             din,
  input  logic                           din_sof,
  input  logic [10:0]                    IW,
  input  logic [10:0]                    IH,
  output logic [KSZ*KSZ*DATAWID-1:0]     window_data_all,
  output logic [DATAWID-1:0]             window_mid,
  output logic                           dout_valid,
  output logic                           dout_sof,
  output logic                           dout_eol,
  output logic                           dout_eof,
  output logic                           cfg_err,
  output logic                           sync_err
);

  localparam int          AW    = (MAX_IW > 1) ? $clog2(MAX_IW) : 1;
  localparam int          NL    = KSZ - 1;
  localparam int          MID   = (KSZ - 1) / 2;
  localparam logic [10:0] KSZ_W = 11'(KSZ);
  localparam logic [10:0] KM1_W = 11'(KSZ - 1);
  localparam logic [11:0] MAX_W = 12'(MAX_IW);

  // position and per-frame geometry
  logic [10:0]        r_col, r_row;
  logic [10:0]        r_iw, r_ih;
  logic               r_geo_ok;
  logic               r_cfg_err, r_sync_err;

  // line RAMs: RAM0 holds the previous line, RAM[NL-1] the oldest
  logic [DATAWID-1:0] r_line [NL][MAX_IW];

  // stage 1: RAM read column plus position flags of the accepted pixel
  logic               r_s1_acc, r_s1_wv, r_s1_sof, r_s1_eol, r_s1_eof;
  logic [DATAWID-1:0] r_s1_pix;
  logic [DATAWID-1:0] r_s1_rd [NL];

  // stage 2: window shift registers and output flags
  logic [DATAWID-1:0] r_sh [KSZ][KSZ];
  logic               r_dvalid, r_dsof, r_deol, r_deof;

  logic [10:0]        w_col, w_row, w_iw, w_ih, w_col_nxt, w_row_nxt;
  logic               w_at_origin, w_geo_ok_in, w_geo_ok, w_col_last, w_row_last, w_win_ok;
  logic [AW-1:0]      w_addr;
  logic [DATAWID-1:0] w_rd [NL];
  logic [DATAWID-1:0] w_wd [NL];

  // Resolve the effective position and geometry of the pixel on the input this cycle
  always_comb begin
    w_col       = din_sof ? 11'd0 : r_col;
    w_row       = din_sof ? 11'd0 : r_row;
    w_at_origin = (w_col == 11'd0) && (w_row == 11'd0);
    // IH is an 11-bit port, so its upper limit of 2047 always holds
    w_geo_ok_in = (IW >= KSZ_W) && ({1'b0, IW} <= MAX_W) && (IH >= KSZ_W);
    w_iw        = w_at_origin ? IW : r_iw;
    w_ih        = w_at_origin ? IH : r_ih;
    w_geo_ok    = w_at_origin ? w_geo_ok_in : r_geo_ok;
    w_col_last  = (w_col == w_iw - 11'd1);
    w_row_last  = (w_row == w_ih - 11'd1);
    w_win_ok    = w_geo_ok && (w_row >= KM1_W) && (w_col >= KM1_W);
    if (w_col_last) begin
      w_col_nxt = 11'd0;
      w_row_nxt = w_row_last ? 11'd0 : w_row + 11'd1;
    end else begin
      w_col_nxt = w_col + 11'd1;
      w_row_nxt = w_row;
    end
    w_addr = w_col[AW-1:0];
  end

  // Read the whole column at the current address; each RAM passes its old word one line down
  always_comb begin
    for (int i = 0; i < NL; i++) begin
      w_rd[i] = r_line[i][w_addr];
    end
    w_wd[0] = din;
    for (int i = 1; i < NL; i++) begin
      w_wd[i] = w_rd[i-1];
    end
  end

  // Counters, geometry latch at (0,0) and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_iw       <= '0;
      r_ih       <= '0;
      r_geo_ok   <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_sync_err <= 1'b0;
    end else if (din_valid) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
      if (w_at_origin) begin
        r_iw     <= IW;
        r_ih     <= IH;
        r_geo_ok <= w_geo_ok_in;
        if (!w_geo_ok_in) begin
          r_cfg_err <= 1'b1;
        end
      end
      if (din_sof && ((r_col != 11'd0) || (r_row != 11'd0))) begin
        r_sync_err <= 1'b1;
      end
    end
  end

  // Line RAM read-before-write and stage-1 data capture; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (din_valid && !rst) begin
      r_s1_pix <= din;
      for (int i = 0; i < NL; i++) begin
        r_s1_rd[i]         <= w_rd[i];
        r_line[i][w_addr]  <= w_wd[i];
      end
    end
  end

  // Stage-1 control: accept strobe, window validity and position flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_acc <= 1'b0;
      r_s1_wv  <= 1'b0;
      r_s1_sof <= 1'b0;
      r_s1_eol <= 1'b0;
      r_s1_eof <= 1'b0;
    end else begin
      r_s1_acc <= din_valid;
      r_s1_wv  <= din_valid && w_win_ok;
      r_s1_sof <= (w_row == KM1_W) && (w_col == KM1_W);
      r_s1_eol <= w_col_last;
      r_s1_eof <= w_col_last && w_row_last;
    end
  end

  // Shift the new column (oldest line at top, live pixel at bottom) into the window
  always_ff @(posedge clk) begin
    if (r_s1_acc) begin
      for (int r = 0; r < KSZ; r++) begin
        for (int c = 0; c < KSZ - 1; c++) begin
          r_sh[r][c] <= r_sh[r][c+1];
        end
      end
      for (int r = 0; r < NL; r++) begin
        r_sh[r][KSZ-1] <= r_s1_rd[NL-1-r];
      end
      r_sh[KSZ-1][KSZ-1] <= r_s1_pix;
    end
  end

  // Output strobe and flags, only ever set together with a valid window
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvalid <= 1'b0;
      r_dsof   <= 1'b0;
      r_deol   <= 1'b0;
      r_deof   <= 1'b0;
    end else begin
      r_dvalid <= r_s1_wv;
      r_dsof   <= r_s1_wv && r_s1_sof;
      r_deol   <= r_s1_wv && r_s1_eol;
      r_deof   <= r_s1_wv && r_s1_eof;
    end
  end

  // Flatten the window; stale shift-register contents are masked while no window is valid
  always_comb begin
    window_data_all = '0;
    window_mid      = '0;
    if (r_dvalid) begin
      for (int r = 0; r < KSZ; r++) begin
        for (int c = 0; c < KSZ; c++) begin
          window_data_all[(r*KSZ+c)*DATAWID +: DATAWID] = r_sh[r][c];
        end
      end
      window_mid = r_sh[MID][MID];
    end
  end

  assign dout_valid = r_dvalid;
  assign dout_sof   = r_dsof;
  assign dout_eol   = r_deol;
  assign dout_eof   = r_deof;
  assign cfg_err    = r_cfg_err;
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_window_buffer_kxk.sv
// tb/tb_window_buffer_kxk.sv - randomized self-checking bench for window_buffer_kxk (KSZ 3 and 5)
module tb_window_buffer_kxk;

  typedef struct {
    int           due;
    logic [3:0]   fl;   // {valid, sof, eol, eof}
    logic [199:0] win;
    logic [7:0]   mid;
  } exp_t;

  logic        clk;
  logic        rst, din_valid, din_sof;
  logic [7:0]  din;
  logic [10:0] IW_s, IH_s;

  logic [71:0]  w3;
  logic [7:0]   mid3;
  logic         dv3, ds3, de3, df3, ce3, se3;
  logic [199:0] w5;
  logic [7:0]   mid5;
  logic         dv5, ds5, de5, df5, ce5, se5;

  window_buffer_kxk #(.KSZ(3), .DATAWID(8), .MAX_IW(1024)) dut3 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_sof(din_sof),
    .IW(IW_s), .IH(IH_s), .window_data_all(w3), .window_mid(mid3),
    .dout_valid(dv3), .dout_sof(ds3), .dout_eol(de3), .dout_eof(df3),
    .cfg_err(ce3), .sync_err(se3));

  window_buffer_kxk #(.KSZ(5), .DATAWID(8), .MAX_IW(1024)) dut5 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_sof(din_sof),
    .IW(IW_s), .IH(IH_s), .window_data_all(w5), .window_mid(mid5),
    .dout_valid(dv5), .dout_sof(ds5), .dout_eol(de5), .dout_eof(df5),
    .cfg_err(ce5), .sync_err(se5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int ecnt  = 0;

  // reference model state: frame image indexed by position
  logic [7:0] img [0:31][0:31];
  int   m_row, m_col, m_iw, m_ih;
  logic m_ok3, m_ok5, m_cfg3, m_cfg5, m_sync;
  exp_t q3[$];
  exp_t q5[$];

  logic [71:0]  log3_win[$];
  logic [2:0]   log3_fl[$];
  logic [199:0] log5_win[$];
  logic [2:0]   log5_fl[$];

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.due = 0;
    e.fl  = '0;
    e.win = '0;
    e.mid = '0;
    return e;
  endfunction

  function automatic logic legal(input int k, input int iw, input int ih);
    return (iw >= k) && (iw <= 1024) && (ih >= k);
  endfunction

  task automatic push_win(input int k, input logic ok, input int r, input int c);
    exp_t e;
    if (!ok || r < k - 1 || c < k - 1) return;
    e = zero_exp();
    e.due = ecnt + 1;
    for (int rr = 0; rr < k; rr++)
      for (int cc = 0; cc < k; cc++)
        e.win[(rr*k+cc)*8 +: 8] = img[r-k+1+rr][c-k+1+cc];
    e.mid = img[r-(k-1)/2][c-(k-1)/2];
    e.fl  = {1'b1, (r == k-1 && c == k-1), (c == m_iw-1), (c == m_iw-1 && r == m_ih-1)};
    if (k == 3) q3.push_back(e);
    else q5.push_back(e);
  endtask

  task automatic model_accept(input logic sof, input logic [7:0] d);
    int r, c;
    if (sof) begin
      if (m_row != 0 || m_col != 0) m_sync = 1'b1;
      m_row = 0;
      m_col = 0;
    end
    r = m_row;
    c = m_col;
    if (r == 0 && c == 0) begin
      m_iw  = int'(IW_s);
      m_ih  = int'(IH_s);
      m_ok3 = legal(3, m_iw, m_ih);
      m_ok5 = legal(5, m_iw, m_ih);
      if (!m_ok3) m_cfg3 = 1'b1;
      if (!m_ok5) m_cfg5 = 1'b1;
    end
    if (r < 32 && c < 32) img[r][c] = d;
    push_win(3, m_ok3, r, c);
    push_win(5, m_ok5, r, c);
    if (c == m_iw - 1) begin
      m_col = 0;
      m_row = (r == m_ih - 1) ? 0 : r + 1;
    end else begin
      m_col = c + 1;
    end
  endtask

  task automatic model_reset();
    q3.delete();
    q5.delete();
    m_row = 0; m_col = 0; m_iw = 0; m_ih = 0;
    m_ok3 = 1'b0; m_ok5 = 1'b0; m_cfg3 = 1'b0; m_cfg5 = 1'b0; m_sync = 1'b0;
  endtask

  // one clock: drive, let the model see the accepted pixel, compare both DUTs mid-cycle
  task automatic step(input logic rv, input logic v, input logic s, input logic [7:0] d);
    exp_t e;
    rst = rv; din_valid = v; din_sof = s; din = d;
    @(posedge clk);
    ecnt++;
    if (rv) model_reset();
    else if (v) model_accept(s, d);
    @(negedge clk);
    e = zero_exp();
    if (q3.size() > 0 && q3[0].due == ecnt) e = q3.pop_front();
    chk("flags3", {dv3, ds3, de3, df3}, e.fl);
    chk("win3", w3, e.win);
    chk("mid3", mid3, e.mid);
    if (dv3) begin log3_win.push_back(w3); log3_fl.push_back({ds3, de3, df3}); end
    e = zero_exp();
    if (q5.size() > 0 && q5[0].due == ecnt) e = q5.pop_front();
    chk("flags5", {dv5, ds5, de5, df5}, e.fl);
    chk("win5", w5, e.win);
    chk("mid5", mid5, e.mid);
    if (dv5) begin log5_win.push_back(w5); log5_fl.push_back({ds5, de5, df5}); end
    chk("err3", {ce3, se3}, {m_cfg3, m_sync});
    chk("err5", {ce5, se5}, {m_cfg5, m_sync});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  // raster frame with data row*16+col; stops before (stop_r, stop_c); IW may change at row 2
  task automatic send_frame(input int iw, input int ih, input int gmax,
                            input int stop_r, input int stop_c, input int iw_late);
    IW_s = 11'(iw);
    IH_s = 11'(ih);
    for (int r = 0; r < ih; r++) begin
      for (int c = 0; c < iw; c++) begin
        if (r > stop_r || (r == stop_r && c >= stop_c)) return;
        if (r == 2 && c == 0 && iw_late > 0) IW_s = 11'(iw_late);
        if (gmax > 0) idle(int'($urandom_range(gmax, 0)));
        step(1'b0, 1'b1, (r == 0 && c == 0), 8'(r*16 + c));
      end
    end
  endtask

  initial begin
    int b3, b5, bA, n_eol, diffs, last;
    logic [7:0] eolv [4];
    eolv[0] = 8'h27; eolv[1] = 8'h37; eolv[2] = 8'h47; eolv[3] = 8'h57;
    rst = 1'b1; din_valid = 1'b0; din_sof = 1'b0; din = '0; IW_s = 11'd8; IH_s = 11'd6;
    model_reset();

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("reset_valid", {dv3, dv5}, 0);
    chk("reset_err", {ce3, se3, ce5, se5}, 0);
    idle(2);

    // 8x6 continuous
    b3 = log3_win.size(); b5 = log5_win.size(); bA = b3;
    send_frame(8, 6, 0, 99, 0, 0);
    idle(3);
    chk("cntA3", log3_win.size() - b3, 24);
    chk("cntA5", log5_win.size() - b5, 8);
    chk("firstA_e00", log3_win[b3][7:0], 8'h00);
    chk("firstA_e11", log3_win[b3][39:32], 8'h11);
    chk("firstA_e22", log3_win[b3][71:64], 8'h22);
    chk("firstA_sof", log3_fl[b3][2], 1'b1);
    n_eol = 0;
    for (int i = b3; i < log3_win.size(); i++) begin
      if (log3_fl[i][1]) begin
        if (n_eol < 4) chk("eolA_pix", log3_win[i][71:64], eolv[n_eol]);
        n_eol++;
      end
    end
    chk("eolA_cnt", n_eol, 4);
    last = log3_win.size() - 1;
    chk("eofA_flag", log3_fl[last][0], 1'b1);
    chk("eofA_e22", log3_win[last][71:64], 8'h57);

    // same frame with random gaps
    b3 = log3_win.size();
    send_frame(8, 6, 3, 99, 0, 0);
    idle(3);
    chk("cntB3", log3_win.size() - b3, 24);
    diffs = 0;
    for (int i = 0; i < 24; i++)
      if (log3_win[b3+i] !== log3_win[bA+i] || log3_fl[b3+i] !== log3_fl[bA+i]) diffs++;
    chk("gap_seq", diffs, 0);

    // 16x10
    b3 = log3_win.size(); b5 = log5_win.size();
    send_frame(16, 10, 1, 99, 0, 0);
    idle(3);
    chk("cntC3", log3_win.size() - b3, 112);
    chk("cntC5", log5_win.size() - b5, 72);
    chk("firstC5_mid", log5_win[b5][103:96], 8'h22);
    chk("firstC5_e44", log5_win[b5][199:192], 8'h44);
    chk("firstC5_e04", log5_win[b5][39:32], 8'h04);

    // back-to-back, IW changed mid frame 1
    b3 = log3_win.size(); b5 = log5_win.size();
    send_frame(8, 6, 0, 99, 0, 12);
    send_frame(12, 6, 0, 99, 0, 0);
    idle(3);
    chk("cntD3", log3_win.size() - b3, 64);
    chk("cntD5", log5_win.size() - b5, 24);
    chk("sync_before", {se3, se5}, 0);

    // din_sof at (3,5)
    b3 = log3_win.size(); b5 = log5_win.size();
    send_frame(8, 6, 2, 3, 5, 0);
    send_frame(8, 6, 0, 99, 0, 0);
    idle(3);
    chk("sync_err", {se3, se5}, 2'b11);
    chk("cntE3", log3_win.size() - b3, 33);
    chk("cntE5", log5_win.size() - b5, 8);
    chk("resync_e22", log3_win[b3+9][71:64], 8'h22);
    chk("resync_sof", log3_fl[b3+9][2], 1'b1);

    // illegal geometry, then recovery
    b3 = log3_win.size(); b5 = log5_win.size();
    send_frame(2, 6, 1, 99, 0, 0);
    idle(3);
    chk("cfg_cnt", (log3_win.size() - b3) + (log5_win.size() - b5), 0);
    chk("cfg_err", {ce3, ce5}, 2'b11);
    b3 = log3_win.size();
    send_frame(8, 6, 1, 99, 0, 0);
    idle(3);
    chk("cntF3", log3_win.size() - b3, 24);

    // reset at pixel (4,4)
    send_frame(8, 6, 0, 4, 5, 0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("rst_valid", {dv3, dv5}, 0);
    chk("rst_err", {ce3, se3, ce5, se5}, 0);
    idle(2);
    b3 = log3_win.size(); b5 = log5_win.size();
    send_frame(8, 6, 2, 99, 0, 0);
    idle(3);
    chk("cntG3", log3_win.size() - b3, 24);
    chk("cntG5", log5_win.size() - b5, 8);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
